vga_rx_monitor: RTL



---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_rx_bbox.sv | 64 ++++++
 rtl/vga_rx_monitor.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, receiver FSM states and the bounding-box record used by
// the VGA receive monitor and its accumulator.
package vga_pkg;
  localparam int          VGA_H_SYNC      = 96;
  localparam int          VGA_H_ACT_START = 144;
  localparam int          VGA_H_VALID     = 640;
  localparam int          VGA_H_TOTAL     = 800;
  localparam int          VGA_V_SYNC      = 2;
  localparam int          VGA_V_ACT_START = 35;
  localparam int          VGA_V_VALID     = 480;
  localparam int          VGA_V_TOTAL     = 525;
  localparam logic [11:0] VGA_BG_COLOR    = 12'hFFF;
  localparam logic        VGA_SYNC_POL    = 1'b1;

  localparam logic [9:0]  CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} vga_rx_state_e;

  typedef struct packed {
    logic [9:0]  x_start;
    logic [9:0]  x_end;
    logic [9:0]  y_start;
    logic [9:0]  y_end;
    logic [11:0] rgb;
    logic        found;
  } bbox_t;

  // Empty accumulator: min at top of range, max at bottom, so the first hit wins both.
  localparam bbox_t BBOX_INIT = '{x_start: CNT_MAX, x_end: 10'd0,
                                  y_start: CNT_MAX, y_end: 10'd0,
                                  rgb: 12'd0, found: 1'b0};

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction
endpackage

// File: rtl/vga_rx_bbox.sv
// Per-frame min/max accumulator of non-background active pixels; publishes the box
// (or all zeros when nothing was found) at frame end and restarts.
module vga_rx_bbox
  import vga_pkg::*;
#(
  parameter logic [11:0] BG_COLOR = VGA_BG_COLOR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        pix_act,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [11:0] pix_rgb,
  input  logic        frame_clr,
  input  logic        frame_end,
  output logic        found,
  output logic [9:0]  x_start,
  output logic [9:0]  x_end,
  output logic [9:0]  y_start,
  output logic [9:0]  y_end,
  output logic [11:0] box_rgb
);
  bbox_t acc, acc_nx, box;
  logic  hit;

  always_comb begin
    acc_nx = acc;
    hit    = ce && pix_act && (pix_rgb != BG_COLOR);
    if (hit) begin
      if (x < acc.x_start) acc_nx.x_start = x;
      if (x > acc.x_end)   acc_nx.x_end   = x;
      if (y < acc.y_start) acc_nx.y_start = y;
      if (y > acc.y_end)   acc_nx.y_end   = y;
      if (!acc.found) begin
        acc_nx.rgb   = pix_rgb;
        acc_nx.found = 1'b1;
      end
    end
  end

  // The pixel sitting in the input stage at the sync edge still belongs to the
  // ending frame, so it is merged before publishing.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= BBOX_INIT;
      box <= '0;
    end else if (ce) begin
      if (frame_clr) begin
        acc <= BBOX_INIT;
        if (frame_end) box <= acc_nx.found ? acc_nx : '0;
      end else begin
        acc <= acc_nx;
      end
    end
  end

  assign found   = box.found;
  assign x_start = box.x_start;
  assign x_end   = box.x_end;
  assign y_start = box.y_start;
  assign y_end   = box.y_end;
  assign box_rgb = box.rgb;
endmodule

// File: rtl/vga_rx_monitor.sv
// VGA sink: recovers raster position from sync edges, checks line/frame timing,
// tracks lock over consecutive clean frames and reports the per-frame character box.
module vga_rx_monitor
  import vga_pkg::*;
#(
  parameter int          H_SYNC      = VGA_H_SYNC,
  parameter int          H_ACT_START = VGA_H_ACT_START,
  parameter int          H_VALID     = VGA_H_VALID,
  parameter int          H_TOTAL     = VGA_H_TOTAL,
  parameter int          V_SYNC      = VGA_V_SYNC,
  parameter int          V_ACT_START = VGA_V_ACT_START,
  parameter int          V_VALID     = VGA_V_VALID,
  parameter int          V_TOTAL     = VGA_V_TOTAL,
  parameter logic [11:0] BG_COLOR    = VGA_BG_COLOR,
  parameter logic        SYNC_POL    = VGA_SYNC_POL
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        pix_ce,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  output logic        locked,
  output logic        timing_err,
  output logic        frame_done,
  output logic [9:0]  h_total_meas,
  output logic [9:0]  v_total_meas,
  output logic        char_found,
  output logic [9:0]  char_x_start,
  output logic [9:0]  char_x_end,
  output logic [9:0]  char_y_start,
  output logic [9:0]  char_y_end,
  output logic [11:0] char_rgb
);
  localparam logic [9:0] HT  = 10'(H_TOTAL);
  localparam logic [9:0] HS  = 10'(H_SYNC);
  localparam logic [9:0] VT  = 10'(V_TOTAL);
  localparam logic [9:0] VS  = 10'(V_SYNC);
  localparam logic [9:0] HA0 = 10'(H_ACT_START);
  localparam logic [9:0] HA1 = 10'(H_ACT_START + H_VALID - 1);
  localparam logic [9:0] VA0 = 10'(V_ACT_START);
  localparam logic [9:0] VA1 = 10'(V_ACT_START + V_VALID - 1);

  logic          hs_q, vs_q;
  logic [11:0]   rgb_q;
  logic [9:0]    h_cnt, v_cnt, h_nxt, v_nxt;
  logic          h_seen;
  vga_rx_state_e state, state_nxt;
  logic [1:0]    good_cnt, good_nxt;
  logic          frame_bad, bad_nxt;
  logic          h_lead, h_trail, v_lead, v_trail, h_sat, v_sat;
  logic          h_len_err, h_wid_err, v_len_err, v_wid_err, mismatch;
  logic          pix_act;
  logic [9:0]    pix_x, pix_y;

  // Edges are seen as the registered sync is about to change, so after the load
  // h_cnt/v_cnt index the very pixel held in rgb_q.
  always_comb begin
    h_lead  = pix_ce && (hsync == SYNC_POL) && (hs_q != SYNC_POL);
    h_trail = pix_ce && (hsync != SYNC_POL) && (hs_q == SYNC_POL);
    v_lead  = pix_ce && (vsync == SYNC_POL) && (vs_q != SYNC_POL);
    v_trail = pix_ce && (vsync != SYNC_POL) && (vs_q == SYNC_POL);

    h_nxt = h_lead ? 10'd0 : sat_inc(h_cnt);
    h_sat = pix_ce && !h_lead && (h_cnt == CNT_MAX);
    v_nxt = v_cnt;
    v_sat = 1'b0;
    if (v_lead) begin
      v_nxt = 10'd0;
    end else if (h_lead) begin
      v_nxt = sat_inc(v_cnt);
      v_sat = (v_cnt == CNT_MAX);
    end

    h_len_err = h_lead  && h_seen && ((h_cnt + 10'd1) != HT);
    h_wid_err = h_trail && h_seen && ((h_cnt + 10'd1) != HS);
    v_len_err = v_lead  && (state != SEARCH) && ((v_cnt + 10'd1) != VT);
    v_wid_err = v_trail && (state != SEARCH) && (v_nxt != VS);
    mismatch  = h_len_err || h_wid_err || v_len_err || v_wid_err || h_sat || v_sat;

    pix_act = (h_cnt >= HA0) && (h_cnt <= HA1) && (v_cnt >= VA0) && (v_cnt <= VA1);
    pix_x   = h_cnt - HA0;
    pix_y   = v_cnt - VA0;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hs_q         <= ~SYNC_POL;
      vs_q         <= ~SYNC_POL;
      rgb_q        <= '0;
      h_cnt        <= '0;
      v_cnt        <= '0;
      h_seen       <= 1'b0;
      h_total_meas <= '0;
      v_total_meas <= '0;
      timing_err   <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      frame_done <= v_lead && (state != SEARCH);
      if (pix_ce) begin
        hs_q  <= hsync;
        vs_q  <= vsync;
        rgb_q <= rgb;
        h_cnt <= h_nxt;
        v_cnt <= v_nxt;
        if (h_lead) begin
          h_seen       <= 1'b1;
          h_total_meas <= h_cnt + 10'd1;
        end
        if (v_lead)   v_total_meas <= v_cnt + 10'd1;
        if (mismatch) timing_err   <= 1'b1;
      end
    end
  end

  // Mismatches flagged on the closing edge belong to the frame that just ended.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    bad_nxt   = v_lead ? 1'b0 : (frame_bad || mismatch);
    case (state)
      SEARCH: begin
        if (v_lead) begin
          state_nxt = MEASURE;
          good_nxt  = 2'd0;
        end
      end
      MEASURE: begin
        if (v_lead) begin
          if (frame_bad || mismatch) begin
            good_nxt = 2'd0;
          end else if (good_cnt == 2'd1) begin
            good_nxt  = 2'd2;
            state_nxt = LOCKED;
          end else begin
            good_nxt = good_cnt + 2'd1;
          end
        end else if (mismatch) begin
          good_nxt = 2'd0;
        end
      end
      LOCKED: begin
        if (mismatch) begin
          state_nxt = MEASURE;
          good_nxt  = 2'd0;
        end
      end
      default: begin
        state_nxt = SEARCH;
        good_nxt  = 2'd0;
      end
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= SEARCH;
      good_cnt  <= 2'd0;
      frame_bad <= 1'b0;
    end else if (pix_ce) begin
      state     <= state_nxt;
      good_cnt  <= good_nxt;
      frame_bad <= bad_nxt;
    end
  end

  assign locked = (state == LOCKED);

  vga_rx_bbox #(
    .BG_COLOR (BG_COLOR)
  ) u_bbox (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .ce        (pix_ce),
    .pix_act   (pix_act),
    .x         (pix_x),
    .y         (pix_y),
    .pix_rgb   (rgb_q),
    .frame_clr (v_lead),
    .frame_end (v_lead && (state != SEARCH)),
    .found     (char_found),
    .x_start   (char_x_start),
    .x_end     (char_x_end),
    .y_start   (char_y_start),
    .y_end     (char_y_end),
    .box_rgb   (char_rgb)
  );
endmodule
